riscv_su_stack_sequencer: RTL and testbench
===========================================

Name: riscv_su_stack_sequencer

Overview:
Sequences the memory beats for interrupt context stacking. On interrupt entry it pushes NUM_REGS context registers from the register file to a descending stack frame; on return it pops them back. It also handles preemption during unstacking (tail-chain back to stacked) and abort. It sits beside the stacking-unit arbiter FSM, consuming its start, return and preemption events, and drives the core's memory request port and register-file side port.

Parameters:
ADDR_WIDTH, 64, stack/memory address width
DATA_WIDTH, 64, register and memory beat width; BYTES = DATA_WIDTH/8
NUM_REGS, 16, registers per context frame (>=2)
IDX_WIDTH, 5, width of register index counter (>= clog2(NUM_REGS+1))
SU_FSM_WIDTH, 3, state encoding width

Ports:
clk  in  1  clock, rising edge
nreset  in  1  asynchronous active-low reset
enable  in  1  0: no new events accepted, no new beats started
i_abort  in  1  abort current stacking/unstacking
i_start  in  1  interrupt entry; begin push
i_ret_interr  in  1  interrupt return; begin pop
i_interr_preemtion  in  1  higher-priority interrupt arrived
i_sp  in  ADDR_WIDTH  current stack pointer, sampled on accepted i_start
o_mem_req  out  1  memory request valid (registered)
o_mem_we  out  1  1 = write (push), 0 = read (pop)
o_mem_addr  out  ADDR_WIDTH  beat address
o_mem_wdata  out  DATA_WIDTH  = i_rf_rdata (combinational)
i_mem_gnt  in  1  request accepted this cycle
i_mem_rvalid  in  1  read data valid
i_mem_rdata  in  DATA_WIDTH  read data
o_rf_idx  out  IDX_WIDTH  register index for current beat
i_rf_rdata  in  DATA_WIDTH  register file read data (async read of o_rf_idx)
o_rf_we  out  1  register file write strobe (1-cycle pulse)
o_rf_wdata  out  DATA_WIDTH  register file write data
o_all_in_stacked  out  1  1-cycle pulse: frame fully stacked
o_all_unstacked  out  1  1-cycle pulse: frame fully restored
o_aborted  out  1  1-cycle pulse: abort completed
o_sp_new  out  ADDR_WIDTH  stack pointer after last completed push/pop
o_fsm_status  out  SU_FSM_WIDTH  current state encoding

Behaviour:
- States: IDLE=0, PUSH=1, STACKED=2, POP=3, POP_WAIT=4. Reset: IDLE, idx=0, base=0, all outputs 0, flags cleared.
- Beat accepted at rising edge where o_mem_req & i_mem_gnt. Once asserted, o_mem_req/addr/we/idx are held stable until gnt; the request is never withdrawn, not even on abort.
- Address arithmetic is modulo 2^ADDR_WIDTH. FRAME = NUM_REGS*BYTES. o_mem_addr = base + idx*BYTES.
- IDLE: i_start & enable & !i_abort -> base <= i_sp - FRAME, idx <= 0, PUSH, o_mem_req=1, we=1 next cycle. Latency is one cycle.
- PUSH: on gnt, idx++. If idx was NUM_REGS-1: -> STACKED, o_mem_req<=0, pulse o_all_in_stacked, o_sp_new<=base. Otherwise o_mem_req stays 1 if enable, giving back-to-back beats at one per cycle. If enable is 0, req drops after the gnt and reasserts when enable returns.
- STACKED: i_ret_interr & enable -> idx<=0, POP, o_mem_req=1, we=0 next cycle. i_start and preemption are ignored.
- POP: on gnt -> POP_WAIT, o_mem_req<=0. Only one read is outstanding at a time.
- POP_WAIT: on i_mem_rvalid: o_rf_we pulse, o_rf_wdata=i_mem_rdata, o_rf_idx=idx; idx++. Next state:
  - idx was NUM_REGS-1 -> IDLE, pulse o_all_unstacked, o_sp_new<=base+FRAME.
  - preempt flag set -> STACKED, pulse o_all_in_stacked, o_sp_new<=base, flag cleared. The frame is still in memory, so no re-push is needed.
  - otherwise -> POP, req reasserted if enable.
  - If last beat and preemption coincide, completion wins and the flag is dropped.
- Preempt flag: set by i_interr_preemtion in POP/POP_WAIT; cleared in every other state.
- Abort: i_abort in IDLE/STACKED -> IDLE next cycle, o_aborted pulse. In PUSH/POP/POP_WAIT it sets an abort flag. The FSM finishes the in-flight beat (gnt for PUSH; rvalid for POP_WAIT; for POP, the outstanding gnt and then its rvalid), then goes IDLE with an o_aborted pulse. Abort has priority over completion and preemption at the same boundary. o_sp_new is unchanged by abort. i_start in the same cycle as abort is ignored.
- i_start outside IDLE and i_ret_interr outside STACKED are ignored.
- Async reset mid-operation: immediate return to reset values; pulses are not emitted.

Test Plan:
- NUM_REGS=4, BYTES=8, i_sp=0x1000, gnt always 1 -> writes to 0xFE0,0xFE8,0xFF0,0xFF8 on 4 consecutive cycles with idx 0..3; o_all_in_stacked one cycle later; o_sp_new=0xFE0; status 2.
- Same push with gnt low for 3 cycles on beat 1 -> addr 0xFE8 and wdata held stable for those 3 cycles; total beats still 4.
- From STACKED, i_ret_interr, rvalid 2 cycles after each gnt with rdata 0xA0..0xA3 -> o_rf_we pulses with idx 0..3 and the matching data; o_all_unstacked; o_sp_new=0x1000; IDLE.
- Preemption during pop beat 1 -> beat 1 rvalid still written to RF; then STACKED, o_all_in_stacked pulse, o_sp_new=0xFE0, no beat 2 request.
- i_abort during push with beat 2 awaiting gnt -> beat 2 completes, no beat 3 request, o_aborted pulse, IDLE, o_sp_new unchanged.
- i_sp=0x10, NUM_REGS=4 -> base wraps to 0xFFFF_FFFF_FFFF_FFF0, and addresses wrap through 0x0 to 0x8. Separately, assert nreset mid-push -> all outputs 0 and IDLE immediately.

Source files
------------

// File: rtl/riscv_su_stack_sequencer.sv
// Interrupt context stacking sequencer: pushes NUM_REGS registers into a descending
// stack frame on entry, pops them back on return, with tail-chain on preemption and abort.
module riscv_su_stack_sequencer #(
  parameter int ADDR_WIDTH   = 64,
  parameter int DATA_WIDTH   = 64,
  parameter int NUM_REGS     = 16,
  parameter int IDX_WIDTH    = 5,
  parameter int SU_FSM_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    nreset,
  input  logic                    enable,
  input  logic                    i_abort,
  input  logic                    i_start,
  input  logic                    i_ret_interr,
  input  logic                    i_interr_preemtion,
  input  logic [ADDR_WIDTH-1:0]   i_sp,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [ADDR_WIDTH-1:0]   o_mem_addr,
  output logic [DATA_WIDTH-1:0]   o_mem_wdata,
  input  logic                    i_mem_gnt,
  input  logic                    i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic [IDX_WIDTH-1:0]    o_rf_idx,
  input  logic [DATA_WIDTH-1:0]   i_rf_rdata,
  output logic                    o_rf_we,
  output logic [DATA_WIDTH-1:0]   o_rf_wdata,
  output logic                    o_all_in_stacked,
  output logic                    o_all_unstacked,
  output logic                    o_aborted,
  output logic [ADDR_WIDTH-1:0]   o_sp_new,
  output logic [SU_FSM_WIDTH-1:0] o_fsm_status
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] FRAME = ADDR_WIDTH'(NUM_REGS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] BEAT  = ADDR_WIDTH'(BYTES);
  localparam logic [IDX_WIDTH-1:0]  LAST  = IDX_WIDTH'(NUM_REGS - 1);

  typedef enum logic [SU_FSM_WIDTH-1:0] {
    IDLE     = SU_FSM_WIDTH'(0),
    PUSH     = SU_FSM_WIDTH'(1),
    STACKED  = SU_FSM_WIDTH'(2),
    POP      = SU_FSM_WIDTH'(3),
    POP_WAIT = SU_FSM_WIDTH'(4)
  } state_t;

  state_t                  state, state_d;
  logic [IDX_WIDTH-1:0]    idx, idx_d;
  logic [ADDR_WIDTH-1:0]   base, base_d;
  logic [ADDR_WIDTH-1:0]   sp_new, sp_d;
  logic                    mem_req, req_d;
  logic                    stk, stk_d, unstk, unstk_d, abt, abt_d;
  logic                    pre_flag, pre_d, abort_flag, abf_d;
  logic                    rf_we, beat, abort_now, pre_now;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= IDLE;
      idx        <= '0;
      base       <= '0;
      sp_new     <= '0;
      mem_req    <= 1'b0;
      stk        <= 1'b0;
      unstk      <= 1'b0;
      abt        <= 1'b0;
      pre_flag   <= 1'b0;
      abort_flag <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      base       <= base_d;
      sp_new     <= sp_d;
      mem_req    <= req_d;
      stk        <= stk_d;
      unstk      <= unstk_d;
      abt        <= abt_d;
      pre_flag   <= pre_d;
      abort_flag <= abf_d;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    base_d    = base;
    sp_d      = sp_new;
    req_d     = mem_req;
    stk_d     = 1'b0;
    unstk_d   = 1'b0;
    abt_d     = 1'b0;
    pre_d     = 1'b0;
    abf_d     = 1'b0;
    rf_we     = 1'b0;
    beat      = mem_req & i_mem_gnt;
    abort_now = abort_flag | i_abort;
    pre_now   = pre_flag | i_interr_preemtion;
    case (state)
      IDLE: begin
        if (i_abort) begin
          abt_d = 1'b1;
        end else if (i_start && enable) begin
          base_d  = i_sp - FRAME;
          idx_d   = '0;
          state_d = PUSH;
          req_d   = 1'b1;
        end
      end
      PUSH: begin
        abf_d = abort_now;
        if (beat) begin
          idx_d = idx + IDX_WIDTH'(1);
          if (abort_now) begin
            state_d = IDLE;
            req_d   = 1'b0;
            abt_d   = 1'b1;
            abf_d   = 1'b0;
          end else if (idx == LAST) begin
            state_d = STACKED;
            req_d   = 1'b0;
            stk_d   = 1'b1;
            sp_d    = base;
          end else begin
            req_d = enable;
          end
        end else if (!mem_req) begin
          // No beat in flight while stalled on enable, so an abort can finish at once.
          if (abort_now) begin
            state_d = IDLE;
            abt_d   = 1'b1;
            abf_d   = 1'b0;
          end else begin
            req_d = enable;
          end
        end
      end
      STACKED: begin
        if (i_abort) begin
          state_d = IDLE;
          abt_d   = 1'b1;
        end else if (i_ret_interr && enable) begin
          idx_d   = '0;
          state_d = POP;
          req_d   = 1'b1;
        end
      end
      POP: begin
        abf_d = abort_now;
        pre_d = pre_now;
        if (beat) begin
          state_d = POP_WAIT;
          req_d   = 1'b0;
        end else if (!mem_req) begin
          if (abort_now) begin
            state_d = IDLE;
            abt_d   = 1'b1;
            abf_d   = 1'b0;
            pre_d   = 1'b0;
          end else begin
            req_d = enable;
          end
        end
      end
      POP_WAIT: begin
        abf_d = abort_now;
        pre_d = pre_now;
        rf_we = i_mem_rvalid;
        if (i_mem_rvalid) begin
          idx_d = idx + IDX_WIDTH'(1);
          abf_d = 1'b0;
          pre_d = 1'b0;
          // Abort outranks completion, which outranks the preemption tail-chain.
          if (abort_now) begin
            state_d = IDLE;
            abt_d   = 1'b1;
          end else if (idx == LAST) begin
            state_d = IDLE;
            unstk_d = 1'b1;
            sp_d    = base + FRAME;
          end else if (pre_now) begin
            state_d = STACKED;
            stk_d   = 1'b1;
            sp_d    = base;
          end else begin
            state_d = POP;
            req_d   = enable;
          end
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign o_mem_req        = mem_req;
  assign o_mem_we         = (state == PUSH);
  assign o_mem_addr       = base + ADDR_WIDTH'(idx) * BEAT;
  assign o_mem_wdata      = i_rf_rdata;
  assign o_rf_idx         = idx;
  assign o_rf_we          = rf_we;
  assign o_rf_wdata       = rf_we ? i_mem_rdata : '0;
  assign o_all_in_stacked = stk;
  assign o_all_unstacked  = unstk;
  assign o_aborted        = abt;
  assign o_sp_new         = sp_new;
  assign o_fsm_status     = state;

endmodule

// File: tb/tb_riscv_su_stack_sequencer.sv
// Self-checking bench: randomized push/pop/preempt/abort traffic against a
// transaction-level model of the stack frame (addresses, data, pulses, stack pointer).
module tb_riscv_su_stack_sequencer;

  localparam int NR = 4;
  localparam logic [63:0] FRAME = 64'(NR * 8);

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        enable, abort, start, ret, preempt, gnt, rvalid;
  logic [63:0] sp_in, rdata;
  logic        mem_req, mem_we, rf_we;
  logic [63:0] mem_addr, mem_wdata, rf_rdata, rf_wdata, sp_new;
  logic [4:0]  rf_idx;
  logic        all_in_stacked, all_unstacked, aborted;
  logic [2:0]  fsm_status;

  logic [63:0] rf_mem [4];
  logic [63:0] frame_data [NR];
  logic [63:0] mem_model [logic [63:0]];
  logic [63:0] exp_sp, cur_base;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;
  assign rf_rdata = rf_mem[rf_idx[1:0]];

  riscv_su_stack_sequencer #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .NUM_REGS(NR), .IDX_WIDTH(5), .SU_FSM_WIDTH(3)
  ) dut (
    .clk(clk), .nreset(nreset), .enable(enable), .i_abort(abort), .i_start(start),
    .i_ret_interr(ret), .i_interr_preemtion(preempt), .i_sp(sp_in),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(gnt), .i_mem_rvalid(rvalid), .i_mem_rdata(rdata),
    .o_rf_idx(rf_idx), .i_rf_rdata(rf_rdata), .o_rf_we(rf_we), .o_rf_wdata(rf_wdata),
    .o_all_in_stacked(all_in_stacked), .o_all_unstacked(all_unstacked), .o_aborted(aborted),
    .o_sp_new(sp_new), .o_fsm_status(fsm_status)
  );

  task automatic randomize_rf;
    for (int i = 0; i < 4; i++) rf_mem[i] = {$urandom, $urandom};
  endtask

  task automatic test_reset;
    nreset = 1'b0; enable = 1'b1; abort = 0; start = 0; ret = 0; preempt = 0;
    gnt = 0; rvalid = 0; sp_in = '0; rdata = '0; exp_sp = '0;
    randomize_rf();
    repeat (2) @(negedge clk);
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, rf_idx, rf_we, rf_wdata, all_in_stacked, all_unstacked,
         aborted, sp_new, fsm_status} !== '0)
      begin fails++; $display("FAIL reset_outputs: got req=%b addr=%h sp=%h st=%0d, expected all 0",
                               mem_req, mem_addr, sp_new, fsm_status); end
    @(negedge clk); nreset = 1'b1; ret = 1'b1;
    @(negedge clk); ret = 1'b0;
    #1;
    tests++;
    if ({mem_req, fsm_status, aborted} !== {1'b0, 3'd0, 1'b0})
      begin fails++; $display("FAIL ret_in_idle: got req=%b st=%0d, expected req=0 st=0", mem_req, fsm_status); end
  endtask

  // Push one frame from sp; rnd randomizes gnt/enable, stall_beat holds gnt low 3 cycles on that beat.
  task automatic test_push(input logic [63:0] sp, input bit rnd, input int stall_beat);
    logic [63:0] base;
    int k, cyc, stalled;
    bit prev_req, prev_gnt, prev_en, exp_req;
    base = sp - FRAME;
    for (int i = 0; i < NR; i++) frame_data[i] = rf_mem[i];
    @(negedge clk); sp_in = sp; start = 1'b1; enable = 1'b1; gnt = 1'b0;
    k = 0; cyc = 0; stalled = 0; prev_req = 1'b1; prev_gnt = 1'b0; prev_en = 1'b1;
    while (k < NR && cyc < 300) begin
      @(negedge clk);
      start = 1'b0; sp_in = {$urandom, $urandom};
      if (rnd) begin
        gnt = ($urandom_range(0, 2) != 0);
        enable = ($urandom_range(0, 3) != 0);
      end else if (k == stall_beat && stalled < 3) begin
        gnt = 1'b0; stalled++;
      end else gnt = 1'b1;
      #1;
      exp_req = (prev_req && !prev_gnt) ? 1'b1 : prev_en;
      tests++;
      if ({mem_req, fsm_status, all_in_stacked, all_unstacked, aborted} !== {exp_req, 3'd1, 3'b000})
        begin fails++; $display("FAIL push_ctrl beat %0d: got req=%b st=%0d pulses=%b%b%b, expected req=%b st=1 pulses=000",
                                 k, mem_req, fsm_status, all_in_stacked, all_unstacked, aborted, exp_req); end
      if (mem_req) begin
        tests++;
        if ({mem_we, mem_addr, rf_idx, mem_wdata} !== {1'b1, base + 64'(k) * 8, 5'(k), frame_data[k]})
          begin fails++; $display("FAIL push_beat %0d: got we=%b addr=%h idx=%0d data=%h, expected we=1 addr=%h idx=%0d data=%h",
                                   k, mem_we, mem_addr, rf_idx, mem_wdata, base + 64'(k) * 8, k, frame_data[k]); end
      end
      prev_req = mem_req; prev_gnt = gnt; prev_en = enable;
      if (mem_req && gnt) begin mem_model[base + 64'(k) * 8] = mem_wdata; k++; end
      cyc++;
    end
    tests++;
    if (k != NR) begin fails++; $display("FAIL push_timeout: got %0d beats, expected %0d", k, NR); end
    if (!rnd) begin
      tests++;
      if (cyc != NR + stalled) begin fails++; $display("FAIL push_cycles: got %0d, expected %0d", cyc, NR + stalled); end
    end
    @(negedge clk); gnt = 1'b0; enable = 1'b1;
    #1;
    tests++;
    if ({all_in_stacked, all_unstacked, aborted, mem_req, fsm_status, sp_new} !== {4'b1000, 3'd2, base})
      begin fails++; $display("FAIL push_done: got pulses=%b%b%b req=%b st=%0d sp=%h, expected 100 req=0 st=2 sp=%h",
                               all_in_stacked, all_unstacked, aborted, mem_req, fsm_status, sp_new, base); end
    exp_sp = base; cur_base = base;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1;
    tests++;
    if ({all_in_stacked, mem_req, fsm_status} !== {2'b00, 3'd2})
      begin fails++; $display("FAIL start_in_stacked: got stk=%b req=%b st=%0d, expected 0 0 2",
                               all_in_stacked, mem_req, fsm_status); end
  endtask

  // Pop the frame at cur_base; preemption is raised while beat pre_beat awaits its read data.
  task automatic test_pop(input int pre_beat, input bit rnd);
    logic [63:0] base, pend_addr;
    int k, cyc, wait_c;
    bit pend, pre_sent, done;
    base = cur_base;
    @(negedge clk); ret = 1'b1; gnt = 1'b0; rvalid = 1'b0; enable = 1'b1;
    k = 0; cyc = 0; wait_c = 0; pend = 0; pre_sent = 0; done = 0; pend_addr = '0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      ret = 1'b0; preempt = 1'b0; rvalid = 1'b0; rdata = {$urandom, $urandom};
      gnt = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pend) begin
        if (wait_c == 0) begin rvalid = 1'b1; rdata = mem_model[pend_addr]; end
        else begin
          wait_c--;
          if (k == pre_beat && !pre_sent) begin preempt = 1'b1; pre_sent = 1'b1; end
        end
      end
      #1;
      tests++;
      if ({mem_req, fsm_status, all_in_stacked, all_unstacked, aborted} !== {!pend, pend ? 3'd4 : 3'd3, 3'b000})
        begin fails++; $display("FAIL pop_ctrl beat %0d: got req=%b st=%0d pulses=%b%b%b, expected req=%b st=%0d pulses=000",
                                 k, mem_req, fsm_status, all_in_stacked, all_unstacked, aborted, !pend, pend ? 4 : 3); end
      if (mem_req) begin
        tests++;
        if ({mem_we, mem_addr, rf_idx} !== {1'b0, base + 64'(k) * 8, 5'(k)})
          begin fails++; $display("FAIL pop_req %0d: got we=%b addr=%h idx=%0d, expected we=0 addr=%h idx=%0d",
                                   k, mem_we, mem_addr, rf_idx, base + 64'(k) * 8, k); end
      end
      tests++;
      if (rvalid) begin
        if ({rf_we, rf_idx, rf_wdata} !== {1'b1, 5'(k), frame_data[k]})
          begin fails++; $display("FAIL pop_rf %0d: got we=%b idx=%0d data=%h, expected we=1 idx=%0d data=%h",
                                   k, rf_we, rf_idx, rf_wdata, k, frame_data[k]); end
      end else if ({rf_we, rf_wdata} !== 65'd0)
        begin fails++; $display("FAIL pop_rf_idle: got we=%b data=%h, expected 0", rf_we, rf_wdata); end
      if (mem_req && gnt) begin
        pend = 1'b1; pend_addr = base + 64'(k) * 8;
        wait_c = rnd ? $urandom_range(1, 3) : 1;
      end else if (rvalid) begin
        pend = 1'b0; k++;
        if (k == NR || pre_sent) done = 1'b1;
      end
      cyc++;
    end
    tests++;
    if (!done) begin fails++; $display("FAIL pop_timeout: got %0d beats, expected completion", k); end
    @(negedge clk); gnt = 1'b0; rvalid = 1'b0; preempt = 1'b0;
    #1;
    exp_sp = (k == NR) ? base + FRAME : base;
    tests++;
    if ({all_in_stacked, all_unstacked, aborted, mem_req, fsm_status, sp_new} !==
        {k != NR, k == NR, 2'b00, (k == NR) ? 3'd0 : 3'd2, exp_sp})
      begin fails++; $display("FAIL pop_done: got pulses=%b%b%b req=%b st=%0d sp=%h, expected stk=%b unstk=%b sp=%h",
                               all_in_stacked, all_unstacked, aborted, mem_req, fsm_status, sp_new,
                               k != NR, k == NR, exp_sp); end
    repeat (3) begin
      @(negedge clk); gnt = 1'b1;
      #1;
      tests++;
      if ({all_in_stacked, all_unstacked, aborted, mem_req, fsm_status} !== {4'b0000, (k == NR) ? 3'd0 : 3'd2})
        begin fails++; $display("FAIL pop_quiet: got pulses=%b%b%b req=%b st=%0d, expected no activity",
                                 all_in_stacked, all_unstacked, aborted, mem_req, fsm_status); end
    end
    gnt = 1'b0;
  endtask

  task automatic test_basic;
    for (int i = 0; i < NR; i++) rf_mem[i] = 64'hA0 + 64'(i);
    test_push(64'h1000, 1'b0, -1);
    test_pop(NR, 1'b0);
  endtask

  task automatic test_stall_preempt;
    randomize_rf();
    test_push(64'h1000, 1'b0, 1);
    test_pop(1, 1'b0);
    test_pop(NR, 1'b0);
  endtask

  task automatic test_wrap;
    randomize_rf();
    test_push(64'h10, 1'b0, -1);
    test_pop(NR, 1'b1);
  endtask

  task automatic test_abort;
    logic [63:0] sp, base;
    sp = {$urandom, $urandom} & ~64'h7;
    base = sp - FRAME;
    randomize_rf();
    for (int i = 0; i < NR; i++) frame_data[i] = rf_mem[i];
    @(negedge clk); start = 1'b1; abort = 1'b1; sp_in = sp;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    #1;
    tests++;
    if ({aborted, mem_req, fsm_status, sp_new} !== {2'b10, 3'd0, exp_sp})
      begin fails++; $display("FAIL abort_idle: got abt=%b req=%b st=%0d sp=%h, expected 1 0 0 %h",
                               aborted, mem_req, fsm_status, sp_new, exp_sp); end
    @(negedge clk); start = 1'b1; gnt = 1'b1;
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      start = 1'b0;
      gnt = (b < 2 || b == 4);
      abort = (b == 2);
      #1;
      tests++;
      if ({mem_req, mem_we, mem_addr, rf_idx, fsm_status} !== {2'b11, base + 64'(b < 2 ? b : 2) * 8, 5'(b < 2 ? b : 2), 3'd1} && b < 5)
        begin fails++; $display("FAIL abort_push_beat %0d: got req=%b addr=%h idx=%0d st=%0d, expected req=1 addr=%h",
                                 b, mem_req, mem_addr, rf_idx, fsm_status, base + 64'(b < 2 ? b : 2) * 8); end
      if (b == 5 && {aborted, all_in_stacked, mem_req, fsm_status, sp_new} !== {3'b100, 3'd0, exp_sp})
        begin fails++; $display("FAIL abort_push_done: got abt=%b stk=%b req=%b st=%0d sp=%h, expected 1 0 0 0 %h",
                                 aborted, all_in_stacked, mem_req, fsm_status, sp_new, exp_sp); end
    end
    repeat (3) begin
      @(negedge clk); gnt = 1'b1;
      #1;
      tests++;
      if ({aborted, mem_req, fsm_status} !== 5'd0)
        begin fails++; $display("FAIL abort_no_beat3: got abt=%b req=%b st=%0d, expected 0 0 0", aborted, mem_req, fsm_status); end
    end
    gnt = 1'b0;
    test_push(sp, 1'b0, -1);
    @(negedge clk); ret = 1'b1;
    @(negedge clk); ret = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0; abort = 1'b1;
    #1;
    tests++;
    if ({mem_req, fsm_status} !== {1'b0, 3'd4})
      begin fails++; $display("FAIL abort_popwait: got req=%b st=%0d, expected 0 4", mem_req, fsm_status); end
    @(negedge clk); abort = 1'b0; rvalid = 1'b1; rdata = mem_model[base];
    #1;
    tests++;
    if ({rf_we, rf_idx, rf_wdata} !== {1'b1, 5'd0, frame_data[0]})
      begin fails++; $display("FAIL abort_pop_rf: got we=%b idx=%0d data=%h, expected 1 0 %h", rf_we, rf_idx, rf_wdata, frame_data[0]); end
    @(negedge clk); rvalid = 1'b0;
    #1;
    tests++;
    if ({aborted, all_unstacked, mem_req, fsm_status, sp_new} !== {3'b100, 3'd0, base})
      begin fails++; $display("FAIL abort_pop_done: got abt=%b req=%b st=%0d sp=%h, expected 1 0 0 %h",
                               aborted, mem_req, fsm_status, sp_new, base); end
    test_push(sp, 1'b0, -1);
    @(negedge clk); abort = 1'b1; ret = 1'b1;
    @(negedge clk); abort = 1'b0; ret = 1'b0;
    #1;
    tests++;
    if ({aborted, mem_req, fsm_status, sp_new} !== {2'b10, 3'd0, base})
      begin fails++; $display("FAIL abort_stacked: got abt=%b req=%b st=%0d sp=%h, expected 1 0 0 %h",
                               aborted, mem_req, fsm_status, sp_new, base); end
  endtask

  task automatic test_reset_mid;
    randomize_rf();
    @(negedge clk); sp_in = 64'h2000; start = 1'b1; gnt = 1'b0;
    @(negedge clk); start = 1'b0; gnt = 1'b1;
    @(negedge clk); gnt = 1'b0;
    #1;
    tests++;
    if ({mem_req, fsm_status} !== {1'b1, 3'd1})
      begin fails++; $display("FAIL reset_mid_pre: got req=%b st=%0d, expected 1 1", mem_req, fsm_status); end
    nreset = 1'b0;
    #1;
    tests++;
    if ({mem_req, mem_we, mem_addr, rf_idx, rf_we, rf_wdata, all_in_stacked, all_unstacked,
         aborted, sp_new, fsm_status} !== '0)
      begin fails++; $display("FAIL reset_mid: got req=%b addr=%h sp=%h st=%0d, expected all 0",
                               mem_req, mem_addr, sp_new, fsm_status); end
    @(negedge clk); nreset = 1'b1;
    @(negedge clk);
    #1;
    tests++;
    if ({mem_req, all_in_stacked, aborted, fsm_status} !== 6'd0)
      begin fails++; $display("FAIL reset_mid_after: got req=%b stk=%b abt=%b st=%0d, expected idle",
                               mem_req, all_in_stacked, aborted, fsm_status); end
    exp_sp = '0;
  endtask

  task automatic test_back_to_back;
    int p;
    for (int it = 0; it < 8; it++) begin
      randomize_rf();
      test_push({$urandom, $urandom} & ~64'h7, 1'b1, -1);
      p = $urandom_range(0, NR);
      test_pop(p, 1'b1);
      if (p < NR - 1) test_pop(NR, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall_preempt();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
